// File: rtl/calc_pkg.sv
// calc_pkg: shared calculator types and constants.
// Used by the BCD entry path, the display path and the ALU.
package calc_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FINISH = 2'd2} state_e;
    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam int CALC_OUT_W = 32;
endpackage

// File: rtl/bcd_digit_sub3.sv
// bcd_digit_sub3: reverse double-dabble correction cell.
// Subtracts 3 from a BCD digit that is 8 or more after the right shift.
module bcd_digit_sub3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    always_comb q = (d >= 4'd8) ? d - 4'd3 : d;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: signed 3-digit BCD entry to 32-bit two's complement.
// Reverse double-dabble, one bit per clock, with start/busy/done framing.
module bcd_to_bin_seq
    import calc_pkg::*;
#(
    parameter int N_DIGITS = 3,
    parameter int BIN_W    = 10,
    parameter int OUT_W    = CALC_OUT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  negativo,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    output logic [OUT_W-1:0]      _output,
    output logic                  busy,
    output logic                  done,
    output logic                  erro
);
    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_e             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_sh, bcd_fix;
    logic [BIN_W-1:0]   bin_q, bin_d, bin_sh;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d, err_q, err_d;
    logic [OUT_W-1:0]   out_q, out_d, mag, signed_val;
    logic               busy_q, busy_d, done_q, done_d, erro_q, erro_d;
    logic               bad_digit;

    assign {bcd_sh, bin_sh} = {bcd_q, bin_q} >> 1;

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_sub3
        bcd_digit_sub3 u_sub3 (.d(bcd_sh[4*k +: 4]), .q(bcd_fix[4*k +: 4]));
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int k = 0; k < N_DIGITS; k++)
            if (bcd_in[4*k +: 4] > BCD_DIGIT_MAX) bad_digit = 1'b1;
    end

    // Sign is applied in the full output width so -999 sign-extends correctly.
    assign mag        = {{(OUT_W - BIN_W){1'b0}}, bin_q};
    assign signed_val = neg_q ? -mag : mag;

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        err_d   = err_q;
        out_d   = out_q;
        erro_d  = erro_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                bcd_d   = bcd_in;
                neg_d   = negativo;
                bin_d   = '0;
                cnt_d   = '0;
                err_d   = bad_digit;
                erro_d  = 1'b0;
                state_d = bad_digit ? FINISH : SHIFT;
            end
            SHIFT: begin
                bcd_d   = bcd_fix;
                bin_d   = bin_sh;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_LAST) ? FINISH : SHIFT;
            end
            FINISH: begin
                out_d   = err_q ? '0 : signed_val;
                erro_d  = err_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            erro_q  <= erro_d;
        end
    end

    assign _output = out_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign erro    = erro_q;
endmodule
